// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: write-side and status bundle between the SFR block and the
// buffered UART transmitter.
//   wr_valid  1-cycle push strobe
//   wr_data   byte to push, sampled with wr_valid
//   ovf_clr   clears the sticky overflow flag
//   full      FIFO holds FIFO_DEPTH bytes
//   empty     FIFO holds no bytes
//   level     stored bytes, excluding the frame in flight
//   overflow  sticky: a push was dropped
// master = SFR side (drives the strobes), slave = transmitter.
interface uart_tx_fifo_if #(
   parameter int unsigned FIFO_DEPTH = 16
);
   localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);

   logic             wr_valid;
   logic [7:0]       wr_data;
   logic             ovf_clr;
   logic             full;
   logic             empty;
   logic [LVL_W-1:0] level;
   logic             overflow;

   modport master (
      output wr_valid, wr_data, ovf_clr,
      input  full, empty, level, overflow
   );

   modport slave (
      input  wr_valid, wr_data, ovf_clr,
      output full, empty, level, overflow
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter. Bytes written by the CPU are queued
// in a small FIFO and serialised LSB-first on tx (8N1, or 8E1 when the
// UART_TX_PARITY_EN macro is defined).
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   bus   uart_tx_fifo_if.slave: wr_valid/wr_data/ovf_clr in,
//         full/empty/level/overflow out
//   busy  frame in progress (FSM not idle)
//   tx    serial line, idle high
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit.
module uart_tx_fifo #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned FIFO_DEPTH   = 16
) (
   input  logic          clk,
   input  logic          rst,
   uart_tx_fifo_if.slave bus,
   output logic          busy,
   output logic          tx
);
   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t           state;
   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [LVL_W-1:0] level_q;
   logic             full_q;
   logic             empty_q;
   logic             ovf_q;
   logic [7:0]       shift;
   logic [2:0]       bit_cnt;
   logic [CNT_W-1:0] baud_cnt;
`ifdef UART_TX_PARITY_EN
   logic             par_q;
`endif

   logic             pop_c;
   logic             push_c;
   logic             drop_c;
   logic             baud_last_c;
   logic             line_c;
   logic [LVL_W-1:0] level_nxt_c;

   // Handshake decode, next FIFO level and the line value for the current state.
   always_comb begin
      pop_c       = (state == S_IDLE) && !empty_q;
      // A pop in the same cycle frees a slot, so a full FIFO can still accept.
      push_c      = bus.wr_valid && (!full_q || pop_c);
      drop_c      = bus.wr_valid && !push_c;
      baud_last_c = (baud_cnt == BAUD_LAST);
      level_nxt_c = level_q;
      if (push_c && !pop_c) begin
         level_nxt_c = level_q + LVL_W'(1);
      end else if (pop_c && !push_c) begin
         level_nxt_c = level_q - LVL_W'(1);
      end
      line_c = 1'b1;
      case (state)
         S_START:  line_c = 1'b0;
         S_DATA:   line_c = shift[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: line_c = par_q;
`endif
         default:  line_c = 1'b1;
      endcase
   end

   // FIFO storage; pointers alone define the contents, so no reset needed.
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem[wr_ptr] <= bus.wr_data;
      end
   end

   // FIFO pointers, level/status flags and sticky overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         ovf_q   <= 1'b0;
      end else begin
         if (push_c) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop_c) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         level_q <= level_nxt_c;
         full_q  <= (level_nxt_c == LVL_FULL);
         empty_q <= (level_nxt_c == '0);
         // Set wins over clear.
         if (drop_c) begin
            ovf_q <= 1'b1;
         end else if (bus.ovf_clr) begin
            ovf_q <= 1'b0;
         end
      end
   end

   // Frame sequencer. tx is registered from the current state's line value,
   // so the line lags the state by one cycle; every bit still lasts
   // CLKS_PER_BIT cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         busy     <= 1'b0;
         tx       <= 1'b1;
         shift    <= '0;
         bit_cnt  <= '0;
         baud_cnt <= '0;
`ifdef UART_TX_PARITY_EN
         par_q    <= 1'b0;
`endif
      end else begin
         tx <= line_c;
         case (state)
            S_IDLE: begin
               if (pop_c) begin
                  shift    <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                  par_q    <= ^mem[rd_ptr];
`endif
                  bit_cnt  <= '0;
                  baud_cnt <= '0;
                  state    <= S_START;
                  busy     <= 1'b1;
               end
            end
            S_START: begin
               if (baud_last_c) begin
                  baud_cnt <= '0;
                  state    <= S_DATA;
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end
            S_DATA: begin
               if (baud_last_c) begin
                  baud_cnt <= '0;
                  shift    <= {1'b0, shift[7:1]};
                  bit_cnt  <= bit_cnt + 3'(1);
                  if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state <= S_PARITY;
`else
                     state <= S_STOP;
`endif
                  end
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (baud_last_c) begin
                  baud_cnt <= '0;
                  state    <= S_STOP;
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end
`endif
            S_STOP: begin
               if (baud_last_c) begin
                  baud_cnt <= '0;
                  state    <= S_IDLE;
                  busy     <= 1'b0;
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.full     = full_q;
   assign bus.empty    = empty_q;
   assign bus.level    = level_q;
   assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed scenarios plus randomized traffic against a
// queue-based model of the transmitter and a line decoder on tx.
module tb_uart_tx_fifo;
   localparam int CPB   = 4;
   localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FB = NB * CPB;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;
   logic tx;

   uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy),
      .tx   (tx)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h cyc=%0d", nm, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0] mq[$];
   logic [7:0] m_sent[$];
   int         fr_j = -1;
   logic [7:0] fr_byte = 8'h00;
   logic       m_ovf = 1'b0;
   logic       m_idle, m_pop, m_drop;

   function automatic logic frame_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
      if (k == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   function automatic logic exp_tx();
      if (fr_j >= 1 && fr_j <= FB) return frame_bit(fr_byte, (fr_j - 1) / CPB);
      return 1'b1;
   endfunction

   // fr_j = cycles since the pop edge of the current frame.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         m_sent.delete();
         fr_j  = -1;
         m_ovf = 1'b0;
      end else begin
         m_idle = (fr_j < 0) || (fr_j >= FB);
         m_pop  = m_idle && (mq.size() > 0);
         m_drop = 1'b0;
         if (m_pop) begin
            fr_byte = mq.pop_front();
            m_sent.push_back(fr_byte);
            fr_j = 0;
         end else if (fr_j >= 0 && fr_j <= FB) begin
            fr_j++;
         end
         if (bus.wr_valid) begin
            if (mq.size() < DEPTH) mq.push_back(bus.wr_data);
            else m_drop = 1'b1;
         end
         if (m_drop) m_ovf = 1'b1;
         else if (bus.ovf_clr) m_ovf = 1'b0;
      end
   end

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      check("tx",       32'(tx),           32'(exp_tx()));
      check("busy",     32'(busy),         32'(fr_j >= 0 && fr_j < FB));
      check("level",    32'(bus.level),    32'(mq.size()));
      check("full",     32'(bus.full),     32'(mq.size() == DEPTH));
      check("empty",    32'(bus.empty),    32'(mq.size() == 0));
      check("overflow", 32'(bus.overflow), 32'(m_ovf));
   end

   // ---------------- line decoder ----------------
   logic [7:0] rx_bytes[$];
   int         rx_starts[$];
   logic       rx_pars[$];
   bit         rx_act = 1'b0;
   logic       rx_prev = 1'b1;
   int         rx_cnt, rx_k, rx_t0;
   logic [7:0] rx_sh;
   logic       rx_par = 1'b0;
   logic [31:0] sb_exp;

   always @(negedge clk or posedge rst) begin
      if (rst) begin
         rx_act  = 1'b0;
         rx_prev = 1'b1;
      end else begin
         if (!rx_act) begin
            if (rx_prev && !tx) begin
               rx_act = 1'b1;
               rx_cnt = 0;
               rx_t0  = cyc;
            end
         end else begin
            rx_cnt++;
            if (rx_cnt % CPB == CPB / 2) begin
               rx_k = rx_cnt / CPB;
               if (rx_k >= 1 && rx_k <= 8) begin
                  rx_sh[rx_k-1] = tx;
               end else if (rx_k == NB - 1) begin
                  check("rx_stop", 32'(tx), 32'd1);
                  sb_exp = (m_sent.size() > 0) ? 32'(m_sent.pop_front()) : 32'h100;
                  check("rx_scoreboard", 32'(rx_sh), sb_exp);
`ifdef UART_TX_PARITY_EN
                  check("rx_parity", 32'(rx_par), 32'(^rx_sh));
`endif
                  rx_bytes.push_back(rx_sh);
                  rx_starts.push_back(rx_t0);
                  rx_pars.push_back(rx_par);
                  rx_act = 1'b0;
               end else begin
                  rx_par = tx;
               end
            end
         end
         rx_prev = tx;
      end
   end

   function automatic int rx_b(input int i);
      if (i < rx_bytes.size()) return int'(rx_bytes[i]);
      return -1;
   endfunction

   function automatic int rx_s(input int i);
      if (i < rx_starts.size()) return rx_starts[i];
      return -1000;
   endfunction

   function automatic int rx_p(input int i);
      if (i < rx_pars.size()) return int'(rx_pars[i]);
      return -1;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic rx_clear();
      rx_bytes.delete();
      rx_starts.delete();
      rx_pars.delete();
   endtask

   task automatic wait_rx(input int n, input int max_cyc, input string nm);
      int k = 0;
      while (rx_bytes.size() < n && k < max_cyc) begin
         tick();
         k++;
      end
      check(nm, 32'(rx_bytes.size()), 32'(n));
   endtask

   task automatic wait_idle(input int max_cyc);
      int k = 0;
      while ((busy || !bus.empty) && k < max_cyc) begin
         tick();
         k++;
      end
      check("idle_reached", {30'd0, busy, !bus.empty}, 32'd0);
   endtask

   int t0, lmax;

   initial begin
      bus.wr_valid = 1'b0;
      bus.wr_data  = 8'h00;
      bus.ovf_clr  = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Reset state
      check("rst_tx",    32'(tx),           32'd1);
      check("rst_busy",  32'(busy),         32'd0);
      check("rst_empty", 32'(bus.empty),    32'd1);
      check("rst_full",  32'(bus.full),     32'd0);
      check("rst_level", 32'(bus.level),    32'd0);
      check("rst_ovf",   32'(bus.overflow), 32'd0);

      // 1: single byte, latency and pattern
      rx_clear();
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'h55;
      tick();
      t0 = cyc;
      bus.wr_valid = 1'b0;
      wait_rx(1, 100, "t1_frames");
      check("t1_latency", 32'(rx_s(0) - t0), 32'd2);
      check("t1_byte",    32'(rx_b(0)),      32'h55);
      repeat (10) tick();
      check("t1_busy",  32'(busy),      32'd0);
      check("t1_empty", 32'(bus.empty), 32'd1);

      // 2: three back-to-back bytes
      rx_clear();
      lmax = 0;
      bus.wr_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.wr_data = 8'(8'h41 + i);
         tick();
         if (int'(bus.level) > lmax) lmax = int'(bus.level);
      end
      bus.wr_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (int'(bus.level) > lmax) lmax = int'(bus.level);
      end
      check("t2_level_peak", 32'(lmax), 32'd2);
      wait_rx(3, 250, "t2_frames");
      check("t2_b0", 32'(rx_b(0)), 32'h41);
      check("t2_b1", 32'(rx_b(1)), 32'h42);
      check("t2_b2", 32'(rx_b(2)), 32'h43);
`ifdef UART_TX_PARITY_EN
      check("t2_gap01", 32'(rx_s(1) - rx_s(0)), 32'd45);
      check("t2_gap12", 32'(rx_s(2) - rx_s(1)), 32'd45);
`else
      check("t2_gap01", 32'(rx_s(1) - rx_s(0)), 32'd41);
      check("t2_gap12", 32'(rx_s(2) - rx_s(1)), 32'd41);
`endif

      // 3: overflow on the 6th byte
      wait_idle(200);
      rx_clear();
      bus.wr_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.wr_data = 8'(8'h10 + i);
         tick();
      end
      bus.wr_valid = 1'b0;
      check("t3_full",  32'(bus.full),     32'd1);
      check("t3_level", 32'(bus.level),    32'd4);
      check("t3_ovf",   32'(bus.overflow), 32'd1);
      bus.ovf_clr = 1'b1;
      tick();
      bus.ovf_clr = 1'b0;
      check("t3_ovf_clr", 32'(bus.overflow), 32'd0);
      wait_rx(5, 400, "t3_frames");
      repeat (60) tick();
      check("t3_count", 32'(rx_bytes.size()), 32'd5);
      for (int i = 0; i < 5; i++) check("t3_byte", 32'(rx_b(i)), 32'(8'h10 + i));

      // 4: push into a full FIFO on the IDLE pop edge
      wait_idle(200);
      rx_clear();
      bus.wr_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.wr_data = 8'(8'h20 + i);
         tick();
         if (i == 0) t0 = cyc;
      end
      bus.wr_valid = 1'b0;
      check("t4_full_before", 32'(bus.full), 32'd1);
      while (cyc < t0 + FB + 1) tick();
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'h2F;
      tick();
      bus.wr_valid = 1'b0;
      check("t4_level", 32'(bus.level),    32'd4);
      check("t4_ovf",   32'(bus.overflow), 32'd0);
      wait_rx(6, 500, "t4_frames");
      check("t4_last", 32'(rx_b(5)), 32'h2F);

      // 5: reset mid-DATA
      wait_idle(300);
      rx_clear();
      bus.wr_valid = 1'b1;
      bus.wr_data = 8'hA3; tick(); t0 = cyc;
      bus.wr_data = 8'h01; tick();
      bus.wr_data = 8'h02; tick();
      bus.wr_valid = 1'b0;
      while (cyc < t0 + 15) tick();
      check("t5_mid_data_tx", 32'(tx), 32'd0);
      rst = 1'b1;
      #1;
      check("t5_rst_tx",    32'(tx),        32'd1);
      check("t5_rst_busy",  32'(busy),      32'd0);
      check("t5_rst_level", 32'(bus.level), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      repeat (100) tick();
      check("t5_no_frames", 32'(rx_bytes.size()), 32'd0);
      check("t5_busy",      32'(busy),            32'd0);

      // 6: parity pattern / frame spacing
      rx_clear();
      bus.wr_valid = 1'b1;
      bus.wr_data = 8'h07; tick();
      bus.wr_data = 8'h03; tick();
      bus.wr_valid = 1'b0;
      wait_rx(2, 300, "t6_frames");
      check("t6_b0", 32'(rx_b(0)), 32'h07);
      check("t6_b1", 32'(rx_b(1)), 32'h03);
`ifdef UART_TX_PARITY_EN
      check("t6_par0", 32'(rx_p(0)), 32'd1);
      check("t6_par1", 32'(rx_p(1)), 32'd0);
      check("t6_gap",  32'(rx_s(1) - rx_s(0)), 32'd45);
`else
      check("t6_gap",  32'(rx_s(1) - rx_s(0)), 32'd41);
`endif

      // Randomized traffic with one reset in the middle
      wait_idle(300);
      for (int i = 0; i < 1500; i++) begin
         bus.wr_valid = ($urandom_range(0, 2) == 0);
         bus.wr_data  = 8'($urandom);
         bus.ovf_clr  = ($urandom_range(0, 15) == 0);
         if (i == 700) rst = 1'b1;
         if (i == 702) rst = 1'b0;
         tick();
      end
      bus.wr_valid = 1'b0;
      bus.ovf_clr  = 1'b0;
      wait_idle(600);
      repeat (20) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
